// File: rtl/slow_tick_phase_sequencer.sv
// Intersection phase sequencer driven by ticks recovered from the divided slow clock,
// with a latched pedestrian walk request and a watchdog that forces a sticky all-red fault.
module slow_tick_phase_sequencer #(
    parameter int GREEN_S     = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int WALK_S      = 15,
    parameter int WDOG_CYCLES = 150_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       slowClk,
    input  logic       walkReq,
    output logic [2:0] nsLight,
    output logic [2:0] ewLight,
    output logic       walkOn,
    output logic [5:0] secRemaining,
    output logic       tick,
    output logic       fault
);

    function automatic logic [5:0] dur(input int s);
        return (s < 1) ? 6'd1 : 6'(s);
    endfunction

    localparam logic [5:0]  GREEN_D   = dur(GREEN_S);
    localparam logic [5:0]  YELLOW_D  = dur(YELLOW_S);
    localparam logic [5:0]  ALLRED_D  = dur(ALLRED_S);
    localparam logic [5:0]  WALK_D    = dur((WALK_S > GREEN_S) ? WALK_S : GREEN_S);
    localparam logic [27:0] WDOG_LAST = 28'(WDOG_CYCLES - 1);

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } phase_e;

    logic        s1_q, s2_q, prev_q, prev_d;
    logic [1:0]  vld_q;
    logic        tick_q, tick_d;
    logic [27:0] wdog_q, wdog_d;
    logic        fault_q, fault_d;
    phase_e      state_q, state_d;
    logic [5:0]  sec_q, sec_d;
    logic        latch_q, latch_d;
    logic        walk_on_q, walk_on_d;
    logic        consume_s;
    logic [2:0]  ns_q, ns_d, ew_q, ew_d;

    // Next-state logic: edge detect, watchdog, phase sequencing and light decode.
    always_comb begin
        // prev only follows s2 once s2 holds a real sample, so a high slowClk at release is no edge
        prev_d    = vld_q[1] ? s2_q : prev_q;
        tick_d    = s2_q & ~prev_q;
        wdog_d    = tick_d ? 28'd0 : (fault_q ? wdog_q : wdog_q + 28'd1);
        fault_d   = fault_q | (wdog_d == WDOG_LAST);
        state_d   = state_q;
        sec_d     = sec_q;
        walk_on_d = walk_on_q;
        consume_s = 1'b0;
        ns_d      = LT_RED;
        ew_d      = LT_RED;

        if (tick_q && !fault_q) begin
            if (sec_q > 6'd1) begin
                sec_d = sec_q - 6'd1;
            end else begin
                case (state_q)
                    ALLRED_A: begin
                        state_d = NS_GREEN;
                        if (latch_q) begin
                            consume_s = 1'b1;
                            sec_d     = WALK_D;
                            walk_on_d = 1'b1;
                        end else begin
                            sec_d     = GREEN_D;
                            walk_on_d = 1'b0;
                        end
                    end
                    NS_GREEN: begin
                        state_d   = NS_YELLOW;
                        sec_d     = YELLOW_D;
                        walk_on_d = 1'b0;
                    end
                    NS_YELLOW: begin
                        state_d = ALLRED_B;
                        sec_d   = ALLRED_D;
                    end
                    ALLRED_B: begin
                        state_d = EW_GREEN;
                        sec_d   = GREEN_D;
                    end
                    EW_GREEN: begin
                        state_d = EW_YELLOW;
                        sec_d   = YELLOW_D;
                    end
                    EW_YELLOW: begin
                        state_d = ALLRED_A;
                        sec_d   = ALLRED_D;
                    end
                    default: begin
                        state_d   = ALLRED_A;
                        sec_d     = ALLRED_D;
                        walk_on_d = 1'b0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end

        // a fresh request outranks the consume so it is served on the following round
        latch_d = walkReq | (latch_q & ~consume_s);

        case (state_d)
            NS_GREEN:  ns_d = LT_GRN;
            NS_YELLOW: ns_d = LT_YEL;
            EW_GREEN:  ew_d = LT_GRN;
            EW_YELLOW: ew_d = LT_YEL;
            default: begin
                ns_d = LT_RED;
                ew_d = LT_RED;
            end
        endcase

        if (fault_d) begin
            state_d   = state_q;
            sec_d     = 6'd0;
            walk_on_d = 1'b0;
            ns_d      = LT_RED;
            ew_d      = LT_RED;
        end else begin
            walk_on_d = walk_on_d;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b1;
            vld_q     <= 2'b00;
            tick_q    <= 1'b0;
            wdog_q    <= 28'd0;
            fault_q   <= 1'b0;
            state_q   <= ALLRED_A;
            sec_q     <= ALLRED_D;
            latch_q   <= 1'b0;
            walk_on_q <= 1'b0;
            ns_q      <= LT_RED;
            ew_q      <= LT_RED;
        end else begin
            s1_q      <= slowClk;
            s2_q      <= s1_q;
            prev_q    <= prev_d;
            vld_q     <= {vld_q[0], 1'b1};
            tick_q    <= tick_d;
            wdog_q    <= wdog_d;
            fault_q   <= fault_d;
            state_q   <= state_d;
            sec_q     <= sec_d;
            latch_q   <= latch_d;
            walk_on_q <= walk_on_d;
            ns_q      <= ns_d;
            ew_q      <= ew_d;
        end
    end

    assign nsLight      = ns_q;
    assign ewLight      = ew_q;
    assign walkOn       = walk_on_q;
    assign secRemaining = sec_q;
    assign tick         = tick_q;
    assign fault        = fault_q;

endmodule
